// File: rtl/piano_pkg.sv
// Shared definitions for the piano recorder/player: key codes, the 28-bit
// note record layout, default timing constants and the key-to-LED decode.
package piano_pkg;

  typedef enum logic [1:0] {
    KEY_NONE = 2'b00,
    KEY_DO   = 2'b01,
    KEY_RE   = 2'b10,
    KEY_MI   = 2'b11
  } key_e;

  // Note record {key[1:0], start_time[12:0], duration[12:0]}
  localparam int unsigned REC_W     = 28;
  localparam int unsigned KEY_MSB   = 27;
  localparam int unsigned KEY_LSB   = 26;
  localparam int unsigned START_MSB = 25;
  localparam int unsigned START_LSB = 13;
  localparam int unsigned DUR_MSB   = 12;
  localparam int unsigned DUR_LSB   = 0;

  typedef struct packed {
    logic [KEY_MSB-KEY_LSB:0]     key;
    logic [START_MSB-START_LSB:0] start_time;
    logic [DUR_MSB-DUR_LSB:0]     duration;
  } note_rec_t;

  // Defaults for a 50 MHz clock
  localparam int unsigned DEF_TICK_DIV = 500000;
  localparam int unsigned DEF_DO_HALF  = 95556;
  localparam int unsigned DEF_RE_HALF  = 85131;
  localparam int unsigned DEF_MI_HALF  = 75843;
  localparam int unsigned HALF_W       = 17;

  // One-hot active-low held-note levels: [2]=do, [1]=re, [0]=mi
  function automatic logic [2:0] key_to_n(key_e k);
    logic [2:0] n;
    case (k)
      KEY_DO:  n = 3'b011;
      KEY_RE:  n = 3'b101;
      KEY_MI:  n = 3'b110;
      default: n = 3'b111;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/song_player_if.sv
// Song RAM read port. master = player (drives rd_addr), slave = RAM
// (returns rd_data one cycle after sampling rd_addr).
interface song_player_if #(
  parameter int unsigned ADDR_W = 13
);
  import piano_pkg::*;

  logic [ADDR_W-1:0] rd_addr;
  logic [REC_W-1:0]  rd_data;

  modport master (output rd_addr, input rd_data);
  modport slave  (input rd_addr, output rd_data);

endinterface

// File: rtl/tone_gen.sv
// Square-wave tone for the held note.
// Ports: clock, resetn (async active-low), cur_key (key that will be held
// from the next edge on), speaker (registered square wave, 0 when silent).
module tone_gen
  import piano_pkg::*;
#(
  parameter int unsigned DO_HALF = DEF_DO_HALF,
  parameter int unsigned RE_HALF = DEF_RE_HALF,
  parameter int unsigned MI_HALF = DEF_MI_HALF
) (
  input  logic clock,
  input  logic resetn,
  input  key_e cur_key,
  output logic speaker
);

  key_e              key_q;
  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              speaker_q, speaker_d;
  logic [HALF_W-1:0] half_m1;

  // Terminal count for the current key
  always_comb begin
    case (cur_key)
      KEY_DO:  half_m1 = HALF_W'(DO_HALF - 1);
      KEY_RE:  half_m1 = HALF_W'(RE_HALF - 1);
      KEY_MI:  half_m1 = HALF_W'(MI_HALF - 1);
      default: half_m1 = '0;
    endcase
  end

  // A key change restarts the waveform from a low phase
  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    speaker_d = speaker_q;
    if ((cur_key != key_q) || (cur_key == KEY_NONE)) begin
      cnt_d     = '0;
      speaker_d = 1'b0;
    end else if (cnt_q == half_m1) begin
      cnt_d     = '0;
      speaker_d = ~speaker_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_q     <= KEY_NONE;
      cnt_q     <= '0;
      speaker_q <= 1'b0;
    end else begin
      key_q     <= cur_key;
      cnt_q     <= cnt_d;
      speaker_q <= speaker_d;
    end
  end

  assign speaker = speaker_q;

endmodule

// File: rtl/song_player.sv
// Song playback engine: steps the RAM address once per tick, latches the
// stored key code and regenerates key levels, a note-start pulse and a tone.
// Ports: clock, resetn (async active-low), play_en (level, rising edge
// restarts from address 0), ram (RAM read port), key_n (active-low held
// note), cur_key, note_start (pulse), speaker, busy, done.
module song_player
  import piano_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned DO_HALF  = DEF_DO_HALF,
  parameter int unsigned RE_HALF  = DEF_RE_HALF,
  parameter int unsigned MI_HALF  = DEF_MI_HALF
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 play_en,
  song_player_if.master        ram,
  output logic [2:0]           key_n,
  output logic [1:0]           cur_key,
  output logic                 note_start,
  output logic                 speaker,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_WAIT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              play_en_d_q;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  key_e              cur_key_q, cur_key_d;
  logic [2:0]        key_n_q, key_n_d;
  logic              note_start_q, note_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  note_rec_t                  rec;
  logic [START_MSB-DUR_LSB:0] unused_fields;

  assign rec           = note_rec_t'(ram.rd_data);
  assign unused_fields = {rec.start_time, rec.duration};

  // Next state and registered outputs
  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    tick_cnt_d   = tick_cnt_q;
    cur_key_d    = cur_key_q;
    note_start_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (play_en && !play_en_d_q) begin
          rd_addr_d  = '0;
          tick_cnt_d = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        tick_cnt_d = tick_cnt_q + 1'b1;
        state_d    = S_LATCH;
      end
      S_LATCH: begin
        tick_cnt_d   = tick_cnt_q + 1'b1;
        cur_key_d    = key_e'(rec.key);
        note_start_d = (cur_key_d != KEY_NONE) && (cur_key_d != cur_key_q);
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (tick_cnt_q == TICK_W'(TICK_DIV - 1)) begin
          if (rd_addr_q != LAST_ADDR) begin
            tick_cnt_d = '0;
            rd_addr_d  = rd_addr_q + 1'b1;
            state_d    = S_FETCH;
          end else begin
            cur_key_d = KEY_NONE;
            state_d   = S_DONE;
          end
        end else begin
          tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        cur_key_d = KEY_NONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Stop wins over everything; the address is kept for inspection
    if (!play_en && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      rd_addr_d    = rd_addr_q;
      tick_cnt_d   = tick_cnt_q;
      cur_key_d    = KEY_NONE;
      note_start_d = 1'b0;
    end

    key_n_d = key_to_n(cur_key_d);
    busy_d  = (state_d == S_FETCH) || (state_d == S_LATCH) || (state_d == S_WAIT);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      play_en_d_q  <= 1'b0;
      rd_addr_q    <= '0;
      tick_cnt_q   <= '0;
      cur_key_q    <= KEY_NONE;
      key_n_q      <= 3'b111;
      note_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      play_en_d_q  <= play_en;
      rd_addr_q    <= rd_addr_d;
      tick_cnt_q   <= tick_cnt_d;
      cur_key_q    <= cur_key_d;
      key_n_q      <= key_n_d;
      note_start_q <= note_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Fed the next-cycle key so the tone restarts on the same edge as key_n
  tone_gen #(
    .DO_HALF (DO_HALF),
    .RE_HALF (RE_HALF),
    .MI_HALF (MI_HALF)
  ) u_tone (
    .clock   (clock),
    .resetn  (resetn),
    .cur_key (cur_key_d),
    .speaker (speaker)
  );

  assign ram.rd_addr = rd_addr_q;
  assign key_n       = key_n_q;
  assign cur_key     = cur_key_q;
  assign note_start  = note_start_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_song_player.sv
// Scoreboard bench for song_player with a 1-cycle behavioural RAM.
module tb_song_player;
  import piano_pkg::*;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned DO_HALF  = 3;
  localparam int unsigned RE_HALF  = 4;
  localparam int unsigned MI_HALF  = 5;
  localparam int          DEPTH    = 1 << ADDR_W;

  logic       clock   = 1'b0;
  logic       resetn  = 1'b1;
  logic       play_en = 1'b0;
  logic [2:0] key_n;
  logic [1:0] cur_key;
  logic       note_start, speaker, busy, done;

  song_player_if #(.ADDR_W(ADDR_W)) ram_if ();

  song_player #(
    .TICK_DIV (TICK_DIV),
    .ADDR_W   (ADDR_W),
    .DO_HALF  (DO_HALF),
    .RE_HALF  (RE_HALF),
    .MI_HALF  (MI_HALF)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .play_en    (play_en),
    .ram        (ram_if),
    .key_n      (key_n),
    .cur_key    (cur_key),
    .note_start (note_start),
    .speaker    (speaker),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  // Behavioural song RAM
  logic [1:0]  ram_key  [DEPTH];
  logic [25:0] ram_rest [DEPTH];
  always @(posedge clock) ram_if.rd_data <= {ram_key[ram_if.rd_addr], ram_rest[ram_if.rd_addr]};

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: held-key timeline and per-tick expected records
  typedef struct { int at; logic [1:0] key; } kev_t;
  typedef struct { int addr; logic [1:0] key; logic ns; } exp_t;
  kev_t kev_q[$];
  exp_t sb_q[$];
  int         seg_start  = 0;
  logic [1:0] seg_key    = 2'b00;
  int         pend_cyc   = -1;
  int         last_fetch = -1;
  logic       prev_busy  = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  int         ns_count   = 0;

  function automatic logic [2:0] exp_key_n(input logic [1:0] k);
    logic [2:0] onehot;
    if (k == 2'd0) return 3'b111;
    onehot = 3'b100 >> (k - 2'd1);
    return ~onehot;
  endfunction

  function automatic int half_of(input logic [1:0] k);
    case (k)
      2'd1:    return DO_HALF;
      2'd2:    return RE_HALF;
      default: return MI_HALF;
    endcase
  endfunction

  // Speaker restarts low when the key changes, then flips every HALF cycles
  function automatic int exp_spk(input int now, input int start, input logic [1:0] k);
    if (k == 2'd0) return 0;
    return ((now - start) / half_of(k)) % 2;
  endfunction

  // Monitor: per-cycle key/tone check plus scoreboard pop two cycles after each fetch
  always @(negedge clock) begin
    kev_t ev;
    exp_t e;
    if (resetn) begin
      while (kev_q.size() > 0 && kev_q[0].at <= cyc) begin
        ev = kev_q.pop_front();
        seg_start = ev.at;
        seg_key   = ev.key;
      end
      check("key_n", int'(key_n), int'(exp_key_n(seg_key)));
      check("cur_key", int'(cur_key), int'(seg_key));
      check("speaker", int'(speaker), exp_spk(cyc, seg_start, seg_key));
      if (note_start) ns_count++;

      if (busy && (!prev_busy || ram_if.rd_addr != prev_addr)) begin
        if (prev_busy) check("tick_period", cyc - last_fetch, TICK_DIV);
        last_fetch = cyc;
        pend_cyc   = cyc + 2;
      end

      if (cyc == pend_cyc) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fetch: addr %0d with nothing expected (cycle %0d)", ram_if.rd_addr, cyc);
        end else begin
          e = sb_q.pop_front();
          check("sb_addr", int'(ram_if.rd_addr), e.addr);
          check("sb_key_n", int'(key_n), int'(exp_key_n(e.key)));
          check("sb_cur_key", int'(cur_key), int'(e.key));
          check("sb_note_start", int'(note_start), int'(e.ns));
        end
      end else begin
        check("note_start_quiet", int'(note_start), 0);
      end
      prev_busy = busy;
      prev_addr = ram_if.rd_addr;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One playback: stop_tick<0 runs to DONE; reset_at>=0 resets at that cycle offset
  task automatic run_play(input int stop_tick, input int hold, input int reset_at);
    int c0, n_addr, end_edge, exp_ns, lat;
    logic [1:0] last;
    logic ns;
    c0       = cyc + 1;
    n_addr   = (stop_tick < 0) ? DEPTH : stop_tick + 1;
    end_edge = (stop_tick < 0) ? c0 + TICK_DIV * DEPTH : c0 + TICK_DIV * stop_tick + 3;
    last     = 2'b00;
    exp_ns   = 0;
    for (int a = 0; a < n_addr; a++) begin
      ns = (ram_key[a] != 2'b00) && (ram_key[a] != last);
      sb_q.push_back('{a, ram_key[a], ns});
      if (ram_key[a] != last) kev_q.push_back('{c0 + 2 + TICK_DIV * a, ram_key[a]});
      if (ns) exp_ns++;
      last = ram_key[a];
    end
    if (last != 2'b00) kev_q.push_back('{end_edge, 2'b00});
    ns_count = 0;
    lat      = -1;
    play_en  = 1'b1;

    for (int i = 1; i <= end_edge - c0; i++) begin
      tick(1);
      if (lat < 0 && key_n != 3'b111) lat = i;
      if (i == 1) begin
        check("start_addr", int'(ram_if.rd_addr), 0);
        check("start_busy", int'(busy), 1);
      end
      if (reset_at >= 0 && i == reset_at + 1) begin
        check("pre_rst_key_n", int'(key_n), 6);
        check("pre_rst_speaker", int'(speaker), 1);
        resetn  = 1'b0;
        play_en = 1'b0;
        kev_q.delete();
        sb_q.delete();
        seg_key    = 2'b00;
        seg_start  = cyc;
        pend_cyc   = -1;
        last_fetch = -1;
        prev_busy  = 1'b0;
        #1;
        check("rst_rd_addr", int'(ram_if.rd_addr), 0);
        check("rst_key_n", int'(key_n), 7);
        check("rst_cur_key", int'(cur_key), 0);
        check("rst_note_start", int'(note_start), 0);
        check("rst_speaker", int'(speaker), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        tick(2);
        resetn = 1'b1;
        tick(2);
        return;
      end
    end
    if (ram_key[0] != 2'b00) check("latency", lat, 3);

    if (stop_tick >= 0) begin
      play_en = 1'b0;
      tick(1);
      check("stop_busy", int'(busy), 0);
      check("stop_key_n", int'(key_n), 7);
      check("stop_speaker", int'(speaker), 0);
      check("stop_addr", int'(ram_if.rd_addr), stop_tick);
      check("stop_done", int'(done), 0);
    end else begin
      tick(1);
      check("done_set", int'(done), 1);
      check("done_busy", int'(busy), 0);
      check("done_addr", int'(ram_if.rd_addr), DEPTH - 1);
      check("done_speaker", int'(speaker), 0);
      tick(hold);
      check("done_hold", int'(done), 1);
      check("done_hold_busy", int'(busy), 0);
      play_en = 1'b0;
      tick(1);
      check("done_clear", int'(done), 0);
    end
    check("note_starts", ns_count, exp_ns);
  endtask

  task automatic load(input logic [1:0] k0, k1, k2, k3, k4, k5, k6, k7);
    ram_key[0] = k0; ram_key[1] = k1; ram_key[2] = k2; ram_key[3] = k3;
    ram_key[4] = k4; ram_key[5] = k5; ram_key[6] = k6; ram_key[7] = k7;
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      ram_rest[a] = 26'($urandom);
      ram_key[a]  = 2'b00;
    end
    #1 resetn = 1'b0;
    #2;
    check("init_rd_addr", int'(ram_if.rd_addr), 0);
    check("init_key_n", int'(key_n), 7);
    check("init_cur_key", int'(cur_key), 0);
    check("init_speaker", int'(speaker), 0);
    check("init_busy", int'(busy), 0);
    check("init_done", int'(done), 0);
    @(posedge clock);
    #1 resetn = 1'b1;
    tick(2);

    // Basic playback to DONE, then hold with play_en high
    load(2'd0, 2'd1, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd0);
    run_play(-1, 6, -1);
    tick(2);

    // Held do for two ticks then mi: tone restart and latency
    load(2'd1, 2'd1, 2'd3, 2'd3, 2'd2, 2'd2, 2'd0, 2'd0);
    run_play(-1, 3, -1);
    tick(1);

    // Stop at address 3, then restart from 0
    load(2'd0, 2'd1, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd0);
    run_play(3, 0, -1);
    tick(3);

    // Randomized songs, random stop point or run to DONE
    repeat (8) begin
      for (int a = 0; a < DEPTH; a++) begin
        ram_key[a]  = 2'($urandom_range(0, 3));
        ram_rest[a] = 26'($urandom);
      end
      if ($urandom_range(0, 2) == 0)
        run_play(-1, int'($urandom_range(1, 6)), -1);
      else
        run_play(int'($urandom_range(0, DEPTH - 1)), 0, -1);
      tick(int'($urandom_range(1, 4)));
    end

    // Reset while mi is held and the speaker is high
    load(2'd0, 2'd1, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd2);
    run_play(-1, 0, 16);

    // Recovery after reset
    load(2'd2, 2'd3, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd2);
    run_play(-1, 2, -1);
    tick(2);

    check("sb_leftover", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/song_player.md
# song_player

Playback engine for the piano recorder. It reads the 28-bit note records {key[1:0], start_time[12:0], duration[12:0]} from the song RAM, one address per 0.01 s tick. It regenerates the held note as active-low key levels, a note-start pulse and a square-wave tone. It is the read-side counterpart of the recorder and time counter, and drives the RAM address while SW[0]=1 (read mode).

## Interface
Parameters:
- TICK_DIV, 500000: clock cycles per playback tick (0.01 s at 50 MHz).
- ADDR_W, 13: RAM address width. Last address is 2^ADDR_W-1.
- DO_HALF, 95556: half-period of "do" in clocks (C4).
- RE_HALF, 85131: half-period of "re" in clocks (D4).
- MI_HALF, 75843: half-period of "mi" in clocks (E4).

Ports:
- clock  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous active-low reset.
- play_en  in  1  level; 1 = play, 0 = stop. A 0→1 edge restarts playback from address 0.
- rd_data  in  28  RAM q; valid one cycle after rd_addr is sampled.
- rd_addr  out  ADDR_W  RAM read address; equals current playback tick index.
- key_n  out  3  active-low held note; [2]=do, [1]=re, [0]=mi.
- cur_key  out  2  decoded key code: 00 none, 01 do, 10 re, 11 mi.
- note_start  out  1  one-cycle pulse when cur_key changes to a nonzero code.
- speaker  out  1  square wave for the held note; 0 when silent.
- busy  out  1  high in FETCH/LATCH/WAIT.
- done  out  1  high in DONE.

## Operation
- Decided: one clock, `clock`. Reset `resetn` is asynchronous, active-low.
- Reset values: rd_addr=0, key_n=3'b111, cur_key=00, note_start=0, speaker=0, busy=0, done=0. FSM is in IDLE, tick and tone counters are 0.
- FSM states:
  - **IDLE**: on a play_en rising edge (registered play_en_d=0, play_en=1), set rd_addr=0 and tick_cnt=0 → FETCH.
  - **FETCH**: one cycle, rd_addr stable → LATCH.
  - **LATCH**: capture rd_data[27:26] into cur_key, update key_n and tone → WAIT.
  - **WAIT**: count tick_cnt. When tick_cnt=TICK_DIV-1:
    - if rd_addr is below the last address: tick_cnt=0, rd_addr+1 → FETCH;
    - if rd_addr is the last address → DONE.
  - **DONE**: key_n=111, cur_key=00, speaker=0, done=1. Holds until play_en=0 → IDLE.
- play_en=0 in any state other than IDLE → IDLE on the next edge. Keys are released, speaker=0, rd_addr is kept.
- tick_cnt keeps running during FETCH/LATCH, so the tick period is exactly TICK_DIV cycles.
- Key decode is one-hot active-low:
  - 01 → 011
  - 10 → 101
  - 11 → 110
  - 00 → 111
- rd_data start_time and duration fields are ignored by playback.
- note_start pulses in the LATCH→WAIT transition cycle only when the new code is nonzero and differs from the previous cur_key. This covers direct changes (01→11) and the first note after silence. Identical consecutive codes give no pulse.
- Tone generator:
  - 17-bit half counter, reloaded to 0 and speaker forced to 0 whenever cur_key changes.
  - While cur_key≠00: when the counter reaches HALF-1 (per key), speaker toggles and the counter clears.
  - While cur_key=00: counter=0, speaker=0.

## Timing
- Latency: rd_addr changes at edge E0 (entering FETCH). RAM samples it at E1. cur_key, key_n and note_start update at E2.
- From the first play_en=1 sample to the first key_n update: 3 cycles.
- Record N is presented for exactly TICK_DIV cycles. Outputs change at a fixed 2-cycle offset after each address step.
- Play_en re-asserted in DONE while still high: ignored, because there is no rising edge.
- Reset asserted mid-tone or mid-fetch: all outputs go to reset values immediately, without waiting for a clock edge.
- Address wrap never occurs: the last address ends playback.

## Structure
- Shared package `piano_pkg` holds:
  - key codes KEY_NONE/KEY_DO/KEY_RE/KEY_MI;
  - the record field positions (KEY_MSB=27, START 25:13, DUR 12:0);
  - the default half-periods and TICK_DIV.
- Sub-module `tone_gen` (cur_key in, speaker out, half-period parameters). Everything else sits in song_player.

## Test plan
Bench uses TICK_DIV=4, ADDR_W=3, DO/RE/MI_HALF=3/4/5, and a behavioural 1-cycle RAM model.
- **Basic playback**: RAM key codes 00,01,01,11,00,10,00,00, play_en 0→1.
  - key_n sequence per tick: 111,011,011,110,111,101,111,111.
  - note_start pulses exactly 3 times.
  - done=1 after 8 ticks.
- **Latency**: measure from play_en sampled high to first key_n update → exactly 3 cycles; rd_addr steps every 4 cycles.
- **Tone**: hold key 01 for 2 ticks.
  - speaker toggles every 3 cycles after LATCH.
  - switching 01→11 resets speaker to 0, then toggles every 5 cycles.
- **Stop mid-play**: drop play_en at address 3 → next edge key_n=111, speaker=0, busy=0. Re-raising play_en restarts at rd_addr=0.
- **Reset mid-play**: pulse resetn low while key_n=110 and speaker=1 → outputs reach reset values before the next clock edge.
- **DONE hold**: keep play_en high after the last address → done stays 1, no new fetch. Cycling play_en 1→0→1 restarts playback.
